ipsxb_distributed_fifo_wr_arb_v1_0: RTL
=======================================

IPSXB_DISTRIBUTED_FIFO_WR_ARB_V1_0 -- requirements
Module: ipsxb_distributed_fifo_wr_arb_v1_0

Interface
REQ-001 Parameter NUM_REQ, default 4: number of write requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 32: payload width.
REQ-003 Parameter DEPTH, default 9: FIFO address width; capacity is 2^DEPTH entries.
REQ-004 Parameter LEN_W, default 8: burst-length field width.
REQ-005 Port clk, input, 1: the only clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port req, input, NUM_REQ: per-requester burst request, level-held.
REQ-008 Port req_len, input, NUM_REQ*LEN_W: per-requester burst length, flat-packed, requester i at [i*LEN_W +: LEN_W].
REQ-009 Port req_valid, input, NUM_REQ: per-requester data valid.
REQ-010 Port req_data, input, NUM_REQ*DATA_WIDTH: per-requester payload, flat-packed.
REQ-011 Port grant, output, NUM_REQ: one-hot burst grant, registered.
REQ-012 Port req_ack, output, NUM_REQ: per-requester word-accepted strobe.
REQ-013 Port fifo_wfull, input, 1: FIFO full flag.
REQ-014 Port fifo_wr_water_level, input, DEPTH+1: FIFO write-side fill level.
REQ-015 Port fifo_w_en, output, 1: FIFO write enable.
REQ-016 Port fifo_wr_data, output, DATA_WIDTH: FIFO write data.
REQ-017 Port busy, output, 1: high while in BURST.

Function
REQ-018 Free space SHALL be computed as free = 2^DEPTH - fifo_wr_water_level, DEPTH+1 bits, unsigned, no wrap.
REQ-019 Requester i SHALL be eligible when req[i]=1, its length is nonzero, and its length <= free; requesters with length 0 are never granted.
REQ-020 The FSM SHALL have two states, IDLE and BURST; reset state is IDLE.
REQ-021 In IDLE, if any requester is eligible, the FSM SHALL select one round-robin, searching from (last_id+1) mod NUM_REQ, latch cur_id and cnt=req_len[cur_id], and go to BURST. grant[cur_id] and busy rise on the next clock (1-cycle request-to-grant latency).
REQ-022 In BURST: fifo_w_en = req_ack[cur_id] = req_valid[cur_id] & !fifo_wfull, combinational, same cycle. fifo_wr_data SHALL equal req_data of cur_id.
REQ-023 Each ack SHALL decrement cnt. An ack while cnt==1 SHALL return the FSM to IDLE, set last_id=cur_id, and drop grant and busy on the next clock.
REQ-024 req_valid gaps in BURST SHALL stall without leaving BURST. Deasserting req mid-burst SHALL NOT end the burst; the granted length is a commitment.
REQ-025 req_ack and fifo_w_en SHALL be 0 in IDLE and for all non-granted requesters.
REQ-026 At most one grant bit, and at most one req_ack bit, SHALL be high in any cycle.
REQ-027 A new grant SHALL NOT issue in the cycle BURST exits. The minimum spacing between the last write of one burst and the first write of the next is 2 cycles, which lets the water level settle.
REQ-028 req_len SHALL be sampled only at grant; later changes SHALL be ignored.
REQ-029 If fifo_wfull is asserted despite the space reservation, writes SHALL stall; no data is dropped or duplicated.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, grant=0, busy=0, cnt=0, cur_id=0, last_id=NUM_REQ-1 (so requester 0 has first priority).
REQ-031 req_ack=0 and fifo_w_en=0 SHALL hold during reset, including reset asserted mid-burst; the remainder of the burst is discarded.

Structure
REQ-032 Package ipsxb_distributed_fifo_arb_pkg SHALL hold the state encoding (IDLE=1'b0, BURST=1'b1) and the default parameter constants.
REQ-033 The round-robin pick SHALL be a separate combinational sub-module ipsxb_rr_pick_v1_0. Inputs: eligible vector and last_id. Outputs: found and index.
REQ-034 All other logic SHALL live in the top module; target size is 120-400 RTL lines.

Verification (DEPTH=4, i.e. 16 entries, NUM_REQ=4)
REQ-035 req=4'b0001, len0=3, level=0, valid held -> grant=0001 one cycle after req; 3 consecutive acks; data words D0,D1,D2 written in order; grant low on the following cycle.
REQ-036 req=4'b1111, all len=1, level=0 -> grants in order 0,1,2,3,0, each burst separated by one IDLE cycle.
REQ-037 level=14, req0 len=4, req1 len=2 -> req1 granted, req0 skipped; req0 granted only once level <= 12.
REQ-038 Mid-burst: valid low for 3 cycles, and separately fifo_wfull forced high for 2 cycles -> no writes during either window; total writes equal len; cnt resumes correctly.
REQ-039 rst pulsed on the 2nd write of a len=5 burst -> next cycle grant=0, busy=0, fifo_w_en=0; the next grant goes to requester 0 first.
REQ-040 req1 len=0 with req=0010 -> no grant ever issues; busy stays 0.

Source files
------------

// File: rtl/ipsxb_distributed_fifo_arb_pkg.sv
// Shared state encoding and default sizing for the distributed FIFO write arbiter.
package ipsxb_distributed_fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 9;
  localparam int DEF_LEN_W      = 8;

endpackage

// File: rtl/ipsxb_rr_pick_v1_0.sv
// Combinational round-robin picker: first eligible index after last_id, wrapping.
module ipsxb_rr_pick_v1_0 #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [ID_W-1:0]    last_id,
  output logic               found,
  output logic [ID_W-1:0]    index
);

  // Scan farthest-to-nearest so the candidate closest to last_id+1 is kept.
  always_comb begin
    int pos;
    found = 1'b0;
    index = '0;
    pos   = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      pos = (int'(last_id) + k) % NUM_REQ;
      if (eligible[pos]) begin
        found = 1'b1;
        index = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/ipsxb_distributed_fifo_wr_arb_v1_0.sv
// Burst write arbiter: grants one requester a whole burst only when the FIFO
// has room for it, then forwards that requester's words until the burst ends.
//
// state | meaning
// IDLE  | no burst owner; pick an eligible requester round-robin
// BURST | cur_id owns the FIFO write port until cnt words are accepted
module ipsxb_distributed_fifo_wr_arb_v1_0
  import ipsxb_distributed_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LEN_W      = DEF_LEN_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*LEN_W-1:0]      req_len,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            req_ack,
  input  logic                          fifo_wfull,
  input  logic [DEPTH:0]                fifo_wr_water_level,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          busy
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [DEPTH:0] CAP = {1'b1, {DEPTH{1'b0}}};

  state_t              state, state_nx;
  logic [ID_W-1:0]     cur_id, cur_id_nx;
  logic [ID_W-1:0]     last_id, last_id_nx;
  logic [LEN_W-1:0]    cnt, cnt_nx;
  logic [NUM_REQ-1:0]  grant_nx;
  logic [NUM_REQ-1:0]  eligible;
  logic                pick_found;
  logic [ID_W-1:0]     pick_idx;
  logic [DEPTH:0]      free;

  // Saturate so a bogus over-capacity level never wraps into a large free count.
  assign free = (fifo_wr_water_level >= CAP) ? '0 : (CAP - fifo_wr_water_level);

  always_comb begin
    logic [LEN_W-1:0] len_i;
    eligible = '0;
    len_i    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      len_i       = req_len[i*LEN_W +: LEN_W];
      eligible[i] = req[i] && (len_i != '0) && (32'(len_i) <= 32'(free));
    end
  end

  ipsxb_rr_pick_v1_0 #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .eligible (eligible),
    .last_id  (last_id),
    .found    (pick_found),
    .index    (pick_idx)
  );

  always_comb begin
    state_nx   = state;
    cur_id_nx  = cur_id;
    last_id_nx = last_id;
    cnt_nx     = cnt;
    req_ack    = '0;
    grant_nx   = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nx  = BURST;
          cur_id_nx = pick_idx;
          cnt_nx    = req_len[pick_idx*LEN_W +: LEN_W];
        end
      end
      BURST: begin
        if (req_valid[cur_id] && !fifo_wfull) begin
          req_ack[cur_id] = 1'b1;
          cnt_nx          = cnt - 1'b1;
          if (cnt <= LEN_W'(1)) begin
            state_nx   = IDLE;
            last_id_nx = cur_id;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // A burst cut by reset must not leak a write in the reset cycle.
    if (rst) begin
      req_ack = '0;
    end
    if (state_nx == BURST) begin
      grant_nx[cur_id_nx] = 1'b1;
    end
  end

  assign fifo_w_en    = |req_ack;
  assign fifo_wr_data = req_data[cur_id*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      busy    <= 1'b0;
      cnt     <= '0;
      cur_id  <= '0;
      last_id <= ID_W'(NUM_REQ - 1);
    end else begin
      state   <= state_nx;
      grant   <= grant_nx;
      busy    <= (state_nx == BURST);
      cnt     <= cnt_nx;
      cur_id  <= cur_id_nx;
      last_id <= last_id_nx;
    end
  end

endmodule
